// File: rtl/parser_dispatch_controller_pkg.sv
// Shared state codes and widths for the parser dispatch controller and its buffer.
package parser_dispatch_controller_pkg;

    localparam int unsigned PDC_STATE_WIDTH = 3;

    typedef enum logic [PDC_STATE_WIDTH-1:0] {
        ST_IDLE               = 3'd0,
        ST_PARSE_DATA         = 3'd1,
        ST_CONTROL            = 3'd2,
        ST_SEND_ANALYSED_DATA = 3'd3,
        ST_SEND_REMAIN        = 3'd4,
        ST_DROP               = 3'd5
    } pdc_state_e;

endpackage

// File: rtl/parser_dispatch_controller.sv
// Header-buffering dispatch controller: parses up to COUNT_META_DATA_MAX beats,
// asks the TCAM for a destination, then replays the buffer and passes the rest.
module parser_dispatch_controller
    import parser_dispatch_controller_pkg::*;
#(
    parameter int unsigned AXIS_DEST_WIDTH     = 2,
    parameter int unsigned COUNT_META_DATA_MAX = 5,
    parameter int unsigned COUNTER_WIDTH       = $clog2(COUNT_META_DATA_MAX + 1),
    parameter int unsigned STATE_WIDTH         = 3,
    parameter int unsigned TCAM_TIMEOUT        = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
    output logic                       m_axis_sel_buffer,
    output logic [STATE_WIDTH-1:0]     state,
    output logic [COUNTER_WIDTH-1:0]   count,
    output logic                       tcam_req,
    input  logic                       tcam_ack,
    input  logic                       tcam_match,
    input  logic                       tcam_drop,
    input  logic [AXIS_DEST_WIDTH-1:0] tcam_dest,
    output logic [31:0]                stat_pkt_count,
    output logic [31:0]                stat_drop_count
);

    localparam int unsigned WAIT_WIDTH = $clog2(TCAM_TIMEOUT + 1);

    pdc_state_e                 state_q;
    logic [COUNTER_WIDTH-1:0]   count_q;
    logic [COUNTER_WIDTH-1:0]   nbeats_q;
    logic                       pkt_done_q;
    logic [WAIT_WIDTH-1:0]      wait_q;
    logic [AXIS_DEST_WIDTH-1:0] dest_q;
    logic [31:0]                pkt_cnt_q;
    logic [31:0]                drop_cnt_q;

    logic in_hs;
    logic out_hs;
    logic last_meta;
    logic last_buf;

    assign in_hs     = s_axis_tvalid && s_axis_tready;
    assign out_hs    = m_axis_tvalid && m_axis_tready;
    assign last_meta = (count_q == COUNTER_WIDTH'(COUNT_META_DATA_MAX - 1));
    assign last_buf  = (count_q == nbeats_q - COUNTER_WIDTH'(1));

    assign state           = STATE_WIDTH'(state_q);
    assign count           = count_q;
    assign m_axis_tdest    = dest_q;
    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_drop_count = drop_cnt_q;

    // Handshake decode; SEND_REMAIN is a direct ingress-to-egress passthrough.
    always_comb begin
        s_axis_tready     = 1'b0;
        m_axis_tvalid     = 1'b0;
        m_axis_tlast      = 1'b0;
        m_axis_sel_buffer = 1'b0;
        tcam_req          = 1'b0;
        case (state_q)
            ST_PARSE_DATA: s_axis_tready = 1'b1;
            ST_CONTROL:    tcam_req      = 1'b1;
            ST_SEND_ANALYSED_DATA: begin
                m_axis_tvalid     = 1'b1;
                m_axis_sel_buffer = 1'b1;
                m_axis_tlast      = pkt_done_q && last_buf;
            end
            ST_SEND_REMAIN: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = s_axis_tlast;
            end
            ST_DROP:       s_axis_tready = !pkt_done_q;
            default:       ;
        endcase
    end

    // Packet FSM with beat index, TCAM wait counter, latched result and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            nbeats_q   <= '0;
            pkt_done_q <= 1'b0;
            wait_q     <= '0;
            dest_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_q <= '0;
                    if (s_axis_tvalid) begin
                        state_q <= ST_PARSE_DATA;
                    end
                end
                ST_PARSE_DATA: begin
                    if (in_hs) begin
                        count_q <= count_q + COUNTER_WIDTH'(1);
                        if (s_axis_tlast || last_meta) begin
                            nbeats_q   <= count_q + COUNTER_WIDTH'(1);
                            pkt_done_q <= s_axis_tlast;
                            wait_q     <= '0;
                            state_q    <= ST_CONTROL;
                        end
                    end
                end
                ST_CONTROL: begin
                    // An ack in the final permitted wait cycle still wins over the timeout.
                    if (tcam_ack) begin
                        if (tcam_match && !tcam_drop) begin
                            dest_q  <= tcam_dest;
                            count_q <= '0;
                            state_q <= ST_SEND_ANALYSED_DATA;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                            state_q    <= ST_DROP;
                        end
                    end else if (wait_q == WAIT_WIDTH'(TCAM_TIMEOUT - 1)) begin
                        drop_cnt_q <= drop_cnt_q + 32'd1;
                        state_q    <= ST_DROP;
                    end else begin
                        wait_q <= wait_q + WAIT_WIDTH'(1);
                    end
                end
                ST_SEND_ANALYSED_DATA: begin
                    if (out_hs) begin
                        count_q <= count_q + COUNTER_WIDTH'(1);
                        if (last_buf) begin
                            if (pkt_done_q) begin
                                pkt_cnt_q <= pkt_cnt_q + 32'd1;
                                count_q   <= '0;
                                state_q   <= ST_IDLE;
                            end else begin
                                state_q <= ST_SEND_REMAIN;
                            end
                        end
                    end
                end
                ST_SEND_REMAIN: begin
                    if (out_hs && s_axis_tlast) begin
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        count_q   <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (pkt_done_q || (in_hs && s_axis_tlast)) begin
                        count_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    count_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parser_dispatch_controller.sv
// Randomized plus directed bench for parser_dispatch_controller against a packet-level model.
module tb_parser_dispatch_controller;

    localparam int unsigned DW = 2;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 3;
    localparam int unsigned META_MAX = 5;
    localparam int unsigned TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [DW-1:0] m_axis_tdest;
    logic          m_axis_sel_buffer;
    logic [SW-1:0] state;
    logic [CW-1:0] count;
    logic          tcam_req, tcam_ack, tcam_match, tcam_drop;
    logic [DW-1:0] tcam_dest;
    logic [31:0]   stat_pkt_count, stat_drop_count;

    parser_dispatch_controller dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .m_axis_tdest(m_axis_tdest), .m_axis_sel_buffer(m_axis_sel_buffer),
        .state(state), .count(count),
        .tcam_req(tcam_req), .tcam_ack(tcam_ack), .tcam_match(tcam_match),
        .tcam_drop(tcam_drop), .tcam_dest(tcam_dest),
        .stat_pkt_count(stat_pkt_count), .stat_drop_count(stat_drop_count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_pkt  = 0;
    int unsigned exp_drop = 0;

    bit         ing_done;
    bit         any_valid;
    int         req_cycles;
    logic       eg_sel[$];
    logic       eg_last[$];
    logic [CW-1:0] eg_cnt[$];
    logic [DW-1:0] eg_dest[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One packet: ingress driver, TCAM responder and egress sink run in parallel.
    task automatic run_packet(input int len, input int ack_dly, input bit match, input bit drp,
                              input logic [DW-1:0] dest, input int bp_pct, input int gap_pct,
                              input bit stall4);
        int nb;
        bit hit;
        nb  = (len < int'(META_MAX)) ? len : int'(META_MAX);
        hit = (ack_dly < int'(TIMEOUT)) && match && !drp;
        eg_sel.delete(); eg_last.delete(); eg_cnt.delete(); eg_dest.delete();
        ing_done = 0; any_valid = 0; req_cycles = 0;
        fork
            begin : ingress
                for (int i = 0; i < len; i++) begin
                    int gaps;
                    int w;
                    gaps = ($urandom_range(99) < 32'(gap_pct)) ? int'($urandom_range(3, 1)) : 0;
                    repeat (gaps) begin
                        @(posedge clk); #1;
                        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                    end
                    @(posedge clk); #1;
                    s_axis_tvalid = 1'b1;
                    s_axis_tlast  = (i == len - 1);
                    w = 0;
                    @(negedge clk);
                    while (!s_axis_tready && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 400) begin
                        check("ingress_timeout", 32'd1, 32'd0);
                        break;
                    end
                    if (state == 3'd1) check("parse_count", 32'(count), 32'(i));
                end
                @(posedge clk); #1;
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                ing_done = 1;
            end
            begin : tcam
                int w;
                int k;
                w = 0; k = 0;
                @(negedge clk);
                while (!tcam_req && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 400) check("req_timeout", 32'd1, 32'd0);
                while (tcam_req && k < 100) begin
                    req_cycles++;
                    if (k == ack_dly) begin
                        tcam_ack = 1'b1; tcam_match = match; tcam_drop = drp; tcam_dest = dest;
                    end else begin
                        tcam_ack = 1'b0; tcam_match = 1'($urandom);
                        tcam_drop = 1'($urandom); tcam_dest = DW'($urandom);
                    end
                    k++;
                    @(negedge clk);
                end
                tcam_ack = 1'b0;
            end
            begin : egress
                int cyc;
                int stall_left;
                bit prev_hold;
                logic [CW-1:0] prev_cnt;
                cyc = 0; stall_left = stall4 ? 4 : 0; prev_hold = 0; prev_cnt = '0;
                while (cyc < 2000) begin
                    @(posedge clk); #1;
                    if (stall_left > 0 && state == 3'd3 && eg_sel.size() == 1) begin
                        m_axis_tready = 1'b0;
                        stall_left--;
                    end else begin
                        m_axis_tready = ($urandom_range(99) >= 32'(bp_pct));
                    end
                    @(negedge clk);
                    if (prev_hold) begin
                        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                        check("hold_count", 32'(count), 32'(prev_cnt));
                    end
                    prev_hold = m_axis_tvalid && !m_axis_tready && m_axis_sel_buffer;
                    prev_cnt  = count;
                    if (m_axis_tvalid) any_valid = 1;
                    if (m_axis_tvalid && m_axis_tready) begin
                        eg_sel.push_back(m_axis_sel_buffer);
                        eg_last.push_back(m_axis_tlast);
                        eg_cnt.push_back(count);
                        eg_dest.push_back(m_axis_tdest);
                    end
                    if (ing_done && state == 3'd0) break;
                    cyc++;
                end
                if (cyc >= 2000) check("pkt_timeout", 32'd1, 32'd0);
                if (stall4) check("stall_used", 32'(stall_left), 32'd0);
            end
        join
        check("req_cycles", 32'(req_cycles),
              (ack_dly < int'(TIMEOUT)) ? 32'(ack_dly + 1) : 32'(TIMEOUT));
        check("egress_beats", 32'(eg_sel.size()), hit ? 32'(len) : 32'd0);
        if (!hit) check("no_valid_on_drop", 32'(any_valid), 32'd0);
        for (int i = 0; i < eg_sel.size(); i++) begin
            check("beat_sel", 32'(eg_sel[i]), 32'(i < nb));
            check("beat_last", 32'(eg_last[i]), 32'(i == len - 1));
            check("beat_dest", 32'(eg_dest[i]), 32'(dest));
            if (i < nb) check("beat_count", 32'(eg_cnt[i]), 32'(i));
        end
        if (hit) exp_pkt++; else exp_drop++;
        check("stat_pkt", stat_pkt_count, exp_pkt);
        check("stat_drop", stat_drop_count, exp_drop);
        check("end_idle", 32'(state), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        tcam_ack = 1'b0; tcam_match = 1'b0; tcam_drop = 1'b0; tcam_dest = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tcam_req", 32'(tcam_req), 32'd0);
        check("rst_tdest", 32'(m_axis_tdest), 32'd0);
        check("rst_stat_pkt", stat_pkt_count, 32'd0);
        check("rst_stat_drop", stat_drop_count, 32'd0);

        run_packet(3, 2, 1, 0, 2'd2, 0, 0, 0);
        run_packet(8, 1, 1, 0, 2'd1, 0, 0, 0);
        run_packet(1, 0, 1, 1, 2'd3, 0, 0, 0);
        run_packet(12, 99, 1, 0, 2'd3, 0, 0, 0);
        run_packet(3, 0, 1, 0, 2'd2, 0, 0, 1);
        run_packet(5, 14, 1, 0, 2'd1, 20, 0, 0);
        run_packet(5, 15, 1, 0, 2'd1, 0, 0, 0);
        run_packet(6, 3, 0, 0, 2'd0, 0, 0, 0);
        run_packet(6, 4, 1, 0, 2'd3, 30, 30, 0);

        // Reset in PARSE_DATA at count=2 abandons the packet.
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
        w = 0;
        @(negedge clk);
        while (!(state == 3'd1 && count == 3'd2) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("mid_rst_reached", 32'(w < 100), 32'd1);
        rst = 1'b1; s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_stat_pkt", stat_pkt_count, 32'd0);
        check("mid_rst_stat_drop", stat_drop_count, 32'd0);
        rst = 1'b0;
        exp_pkt = 0; exp_drop = 0;
        run_packet(4, 3, 1, 0, 2'd3, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int len, dly;
            bit mt, dr;
            len = int'($urandom_range(12, 1));
            dly = ($urandom_range(99) < 70) ? int'($urandom_range(8)) : int'($urandom_range(20, 12));
            mt  = ($urandom_range(99) < 80);
            dr  = ($urandom_range(99) < 15);
            run_packet(len, dly, mt, dr, DW'($urandom), int'($urandom_range(50)),
                       int'($urandom_range(40)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
